// File: rtl/race_launcher.sv
// Transmit end of the race-logic edge interface: fires boundary edges into the
// systolic alignment array on a gap-penalty schedule and times the sink edge.
module race_launcher #(
    parameter int N_ROWS      = 8,
    parameter int N_COLS      = 8,
    parameter int DELAY_WIDTH = 4,
    parameter int TIME_WIDTH  = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_valid,
    output logic                   start_ready,
    input  logic [DELAY_WIDTH-1:0] indel_delay,
    output logic                   edge_corner,
    output logic [N_COLS-1:0]      edge_top,
    output logic [N_ROWS-1:0]      edge_left,
    input  logic                   sink_edge,
    output logic [TIME_WIDTH-1:0]  score,
    output logic                   timeout,
    output logic                   done_valid,
    input  logic                   done_ready
);

    localparam int MAXL = (N_ROWS > N_COLS) ? N_ROWS : N_COLS;
    localparam int LW   = (MAXL > 1) ? $clog2(MAXL) : 1;

    localparam logic [LW-1:0]          LAST_LANE = LW'(MAXL - 1);
    localparam logic [LW-1:0]          LANE_INC  = LW'(1);
    localparam logic [MAXL-1:0]        LANE_ONE  = MAXL'(1);
    localparam logic [TIME_WIDTH-1:0]  T_MAX     = '1;
    localparam logic [TIME_WIDTH-1:0]  T_ONE     = TIME_WIDTH'(1);
    localparam logic [DELAY_WIDTH-1:0] STEP_ONE  = DELAY_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} state_t;

    state_t                 state_q;
    logic [DELAY_WIDTH-1:0] delay_q;
    logic [DELAY_WIDTH-1:0] step_q;
    logic [LW-1:0]          lane_q;
    logic [TIME_WIDTH-1:0]  time_q;
    logic [MAXL-1:0]        lanes_q;
    logic [TIME_WIDTH-1:0]  score_q;
    logic                   timeout_q;
    logic                   done_valid_q;

    logic [TIME_WIDTH-1:0]  time_d;
    logic [MAXL-1:0]        lane_hot;
    logic                   finish;

    // The score is the post-increment time, so a sink seen on the launch edge scores 1.
    always_comb begin
        time_d   = (time_q == T_MAX) ? T_MAX : time_q + T_ONE;
        lane_hot = LANE_ONE << lane_q;
        finish   = sink_edge || (time_d == T_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            delay_q      <= '0;
            step_q       <= '0;
            lane_q       <= '0;
            time_q       <= '0;
            lanes_q      <= '0;
            score_q      <= '0;
            timeout_q    <= 1'b0;
            done_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_valid) begin
                        delay_q <= indel_delay;
                        step_q  <= '0;
                        lane_q  <= '0;
                        time_q  <= '0;
                        state_q <= LAUNCH;
                    end
                end
                LAUNCH, WAIT: begin
                    time_q <= time_d;
                    if (state_q == LAUNCH) begin
                        // Lane L fires L*D edges after lane 0; step_q counts down the gap.
                        if (delay_q == '0) begin
                            lanes_q <= '1;
                            state_q <= WAIT;
                        end else if (step_q == '0) begin
                            lanes_q <= lanes_q | lane_hot;
                            step_q  <= delay_q - STEP_ONE;
                            if (lane_q == LAST_LANE) begin
                                state_q <= WAIT;
                            end else begin
                                lane_q <= lane_q + LANE_INC;
                            end
                        end else begin
                            step_q <= step_q - STEP_ONE;
                        end
                    end
                    if (finish) begin
                        score_q      <= time_d;
                        timeout_q    <= ~sink_edge;
                        done_valid_q <= 1'b1;
                        state_q      <= DONE;
                    end
                end
                DONE: begin
                    if (done_ready) begin
                        lanes_q      <= '0;
                        done_valid_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign start_ready = (state_q == IDLE);
    assign edge_corner = lanes_q[0];
    assign edge_top    = lanes_q[N_COLS-1:0];
    assign edge_left   = lanes_q[N_ROWS-1:0];
    assign score       = score_q;
    assign timeout     = timeout_q;
    assign done_valid  = done_valid_q;

endmodule

// File: tb/tb_race_launcher.sv
// Randomized self-checking bench for race_launcher against an arithmetic model
// of the launch schedule, race timing and handshakes.
module tb_race_launcher;

    localparam int NR   = 4;
    localparam int NC   = 6;
    localparam int DW   = 4;
    localparam int TW   = 8;
    localparam int TMAX = (1 << TW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_valid;
    logic          start_ready;
    logic [DW-1:0] indel_delay;
    logic          edge_corner;
    logic [NC-1:0] edge_top;
    logic [NR-1:0] edge_left;
    logic          sink_edge;
    logic [TW-1:0] score;
    logic          timeout;
    logic          done_valid;
    logic          done_ready;

    int checkCount = 0;
    int errCount   = 0;

    race_launcher #(
        .N_ROWS(NR), .N_COLS(NC), .DELAY_WIDTH(DW), .TIME_WIDTH(TW)
    ) dut (
        .clk(clk), .rst(rst),
        .start_valid(start_valid), .start_ready(start_ready),
        .indel_delay(indel_delay),
        .edge_corner(edge_corner), .edge_top(edge_top), .edge_left(edge_left),
        .sink_edge(sink_edge),
        .score(score), .timeout(timeout),
        .done_valid(done_valid), .done_ready(done_ready)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Lane i of an n-lane side is high jj edges into the race if its launch time 1+i*d has passed.
    function automatic logic [31:0] expLanes(input int d, input int jj, input int n);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < n; i++)
            if (jj >= 1 && (d == 0 || 1 + i * d <= jj)) m[i] = 1'b1;
        return m;
    endfunction

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_rdy"}, 32'(start_ready), 32'd1);
        checkOutput({tag, "_dv"}, 32'(done_valid), 32'd0);
        checkOutput({tag, "_top"}, 32'(edge_top), 32'd0);
        checkOutput({tag, "_left"}, 32'(edge_left), 32'd0);
        checkOutput({tag, "_corner"}, 32'(edge_corner), 32'd0);
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic applyStimulus(input int d, input int sinkAt, input int hold);
        int jend;
        int expTo;
        int jj;
        jend  = (sinkAt <= TMAX) ? sinkAt : TMAX;
        expTo = (sinkAt <= TMAX) ? 0 : 1;
        checkOutput("pre_rdy", 32'(start_ready), 32'd1);
        start_valid = 1'b1;
        indel_delay = DW'(d);
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        indel_delay = DW'($urandom);
        for (int j = 1; j <= jend + hold; j++) begin
            sink_edge   = (j >= sinkAt);
            start_valid = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
            jj = (j < jend) ? j : jend;
            checkOutput("top", 32'(edge_top), expLanes(d, jj, NC));
            checkOutput("left", 32'(edge_left), expLanes(d, jj, NR));
            checkOutput("corner", 32'(edge_corner), 32'd1);
            checkOutput("rdy_busy", 32'(start_ready), 32'd0);
            checkOutput("dv", 32'(done_valid), (j >= jend) ? 32'd1 : 32'd0);
            if (j >= jend) begin
                checkOutput("score", 32'(score), 32'(jend));
                checkOutput("timeout", 32'(timeout), 32'(expTo));
            end
        end
        start_valid = 1'b0;
        done_ready  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        done_ready = 1'b0;
        checkIdle("clear");
        checkOutput("score_kept", 32'(score), 32'(jend));
        sink_edge = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        start_valid = 1'b0;
        indel_delay = '0;
        sink_edge   = 1'b0;
        done_ready  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkIdle("reset");
        checkOutput("reset_score", 32'(score), 32'd0);
        checkOutput("reset_to", 32'(timeout), 32'd0);

        // Stale sink while idle must not start or finish anything.
        sink_edge = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkIdle("stale");
        sink_edge = 1'b0;

        applyStimulus(3, 20, 2);
        applyStimulus(0, 6, 5);
        applyStimulus(15, 300, 1);
        applyStimulus(2, TMAX, 0);
        applyStimulus(5, 1, 3);
        applyStimulus(1, 4, 0);

        // Reset in the middle of the launch, after lane 1 has fired.
        start_valid = 1'b1;
        indel_delay = DW'(3);
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checkOutput("mid_top", 32'(edge_top), 32'h3);
        rst         = 1'b1;
        start_valid = 1'b1;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            checkIdle("midrst");
        end
        rst         = 1'b0;
        start_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkIdle("postrst");

        for (int r = 0; r < 14; r++) begin
            int d;
            int s;
            d = int'($urandom_range(0, 15));
            s = ($urandom_range(0, 4) == 0) ? 400 : int'($urandom_range(1, 90));
            applyStimulus(d, s, int'($urandom_range(0, 5)));
        end

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule

// File: doc/race_launcher.md
Name: race_launcher

Overview:
- Transmit end of the race-logic edge interface. Injects rising edges into the boundary cells of the systolic alignment array: corner, top row, left column.
- Boundary edges fire at gap-penalty-scaled times; the block then times the race until the sink cell's edge arrives.
- Sits between the host-side control and the cell array; returns the arrival time as the binary alignment score.

Parameters:
- N_ROWS, 8, number of left-column boundary lanes
- N_COLS, 8, number of top-row boundary lanes
- DELAY_WIDTH, 4, width of the per-step indel delay (matches cell delay width)
- TIME_WIDTH, 12, width of the race time counter and the score

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start_valid  in  1  launch request
- start_ready  out  1  high only in IDLE
- indel_delay  in  DELAY_WIDTH  boundary step delay D, sampled on start handshake
- edge_corner  out  1  edge into cell (0,0)
- edge_top  out  N_COLS  edges into top-row cells; bit i = column i
- edge_left  out  N_ROWS  edges into left-column cells; bit j = row j
- sink_edge  in  1  edge from the bottom-right cell (level, stays high once risen)
- score  out  TIME_WIDTH  race arrival time
- timeout  out  1  race did not finish before counter saturation
- done_valid  out  1  result available
- done_ready  in  1  result consumed

Behaviour:
- Reset: state IDLE; all edge outputs 0; score 0; timeout 0; done_valid 0; start_ready 1 in the cycle after reset deasserts.
- Reset mid-operation: everything returns to reset values on the next edge. Edges drop, so the array sees a clear.
- States: IDLE -> LAUNCH -> WAIT -> DONE -> IDLE.
- IDLE:
  - start_ready=1.
  - On start_valid&start_ready at edge k: latch D=indel_delay, clear the time counter T, lane index L=0, step counter S=0, go to LAUNCH.
- LAUNCH:
  - At edge k+1: edge_corner, edge_top[0] and edge_left[0] are set, and T becomes 1.
  - Lane L (L>=1) is set at edge k+1+L*D. A subtract/compare step counter S is used; no multiplier.
  - When D=0, all lanes are set at edge k+1.
  - Lanes with index >= N_COLS (top) or >= N_ROWS (left) are ignored.
  - Once set, an edge stays high (race-logic level encoding) until the return to IDLE.
  - When lane max(N_ROWS,N_COLS)-1 is set, go to WAIT.
  - sink_edge is also monitored during LAUNCH.
- T (time counter):
  - Increments every cycle in LAUNCH and WAIT.
  - Saturates at 2^TIME_WIDTH-1; no wrap.
- Sink detection:
  - The first cycle in LAUNCH or WAIT with sink_edge=1 captures score=T and timeout=0, then goes to DONE.
  - Score is therefore the number of cycles from corner-edge assertion to sink observation, inclusive of the launch cycle.
- Timeout: if T reaches saturation with sink_edge=0, capture score=all-ones and timeout=1, then go to DONE.
- Simultaneous saturation and sink_edge: sink wins; score=all-ones, timeout=0.
- DONE:
  - done_valid=1; score and timeout stable; edge outputs held.
  - On done_valid&done_ready: next cycle all edges=0, done_valid=0, state IDLE. start_ready rises that same cycle.
- sink_edge high already in IDLE (stale array): ignored. It is only sampled in LAUNCH/WAIT.
- start_valid while not IDLE: ignored (no ready).
- indel_delay changes after the handshake: no effect on the current race.

Test Plan:
- Reset then idle: rst high 2 cycles -> all edges 0, done_valid 0, start_ready 1.
- Launch schedule: N_ROWS=N_COLS=4, D=3, start at edge k -> edge_top/edge_left bits 0,1,2,3 rise at k+1, k+4, k+7, k+10; corner at k+1; stay high.
- D=0 and sink: all lanes rise at k+1; sink_edge driven at edge k+6 -> score=6, timeout=0, done_valid high until done_ready.
- Timeout: TIME_WIDTH=6, sink_edge never asserted -> at T=63, score=63, timeout=1, done_valid=1.
- Backpressure and clear: done_ready low 5 cycles -> outputs held; done_ready high -> next cycle edges 0, start_ready 1; new start accepted immediately.
- Reset mid-LAUNCH: rst asserted after lane 1 fires -> next cycle all edges 0, state IDLE; start_valid ignored while rst is high.
